// File: rtl/objram_dbuf.sv
// Double-buffered sprite object RAM: CPU-side source bank, row-wide display bank, DMA copy engine.
// Optional build macro OBJRAM_DMA_CLEAR_EN: the copy also zeroes each source row after reading it.
module objram_dbuf #(
  parameter int WORD_W = 16,
  parameter int COLS   = 4,
  parameter int ROWS   = 512,
  localparam int AW    = $clog2(ROWS*COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int BE    = WORD_W/8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          cpu_addr,
  input  logic                   cpu_we,
  input  logic [BE-1:0]          cpu_be,
  input  logic [WORD_W-1:0]      cpu_din,
  output logic [WORD_W-1:0]      cpu_dout,
  input  logic                   dma_start,
  input  logic [RW:0]            dma_rows,
  output logic                   dma_busy,
  output logic                   dma_done,
  input  logic [RW-1:0]          disp_row,
  output logic [COLS*WORD_W-1:0] disp_q
);

  localparam int CW = $clog2(COLS);
  localparam int DW = COLS*WORD_W;
  localparam int NB = COLS*BE;
  localparam logic [RW:0] ROWS_C = (RW+1)'(ROWS);

`ifdef OBJRAM_DMA_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;
`endif

  logic [DW-1:0] src_mem  [ROWS];
  logic [DW-1:0] disp_mem [ROWS];

  state_t        state_q, state_d;
  logic [RW:0]   cnt_q, cnt_d;
  logic [RW:0]   num_q, num_d;
  logic          wr_vld_q, wr_vld_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [DW-1:0] src_rd_q;
  logic [DW-1:0] cpu_row_q;
  logic [CW-1:0] cpu_col_q;
  logic [DW-1:0] disp_data_q;

  logic [RW-1:0] cpu_row;
  logic [CW-1:0] cpu_col;
  logic [NB-1:0] be_mask;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
`ifdef OBJRAM_DMA_CLEAR_EN
  logic          clr_en;
`endif

  assign cpu_row = cpu_addr[AW-1:CW];
  assign cpu_col = cpu_addr[CW-1:0];
  assign wdata   = {COLS{cpu_din}};

  // Byte-enable mask: cpu_be placed at the addressed column only
  always_comb begin
    be_mask = '0;
    for (int c = 0; c < COLS; c++) begin
      if (cpu_col == CW'(c)) be_mask[c*BE +: BE] = cpu_be;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    wr_vld_d = 1'b0;
    wr_row_d = wr_row_q;
    busy     = 1'b0;
    done     = 1'b0;
`ifdef OBJRAM_DMA_CLEAR_EN
    clr_en   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          if (dma_rows == '0) begin
            state_d = S_DONE;
          end else begin
            num_d   = (dma_rows > ROWS_C) ? ROWS_C : dma_rows;
            cnt_d   = '0;
            state_d = S_COPY;
          end
        end
      end
`ifdef OBJRAM_DMA_CLEAR_EN
      S_COPY: begin
        busy     = 1'b1;
        wr_vld_d = 1'b1;
        wr_row_d = cnt_q[RW-1:0];
        cnt_d    = cnt_q + (RW+1)'(1);
        state_d  = S_CLEAR;
      end
      S_CLEAR: begin
        busy    = 1'b1;
        // A CPU write landing on the row being cleared takes priority
        clr_en  = !(cpu_we && (cpu_row == wr_row_q));
        state_d = (cnt_q == num_q) ? S_DONE : S_COPY;
      end
`else
      S_COPY: begin
        busy = 1'b1;
        if (cnt_q != num_q) begin
          wr_vld_d = 1'b1;
          wr_row_d = cnt_q[RW-1:0];
          cnt_d    = cnt_q + (RW+1)'(1);
        end else begin
          // Last read already issued; this cycle drains the final display write
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      wr_vld_q <= 1'b0;
      wr_row_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      wr_vld_q <= wr_vld_d;
      wr_row_q <= wr_row_d;
    end
  end

  // Source bank: port A CPU byte writes, port B DMA read (and clear)
  always_ff @(posedge clk) begin
`ifdef OBJRAM_DMA_CLEAR_EN
    if (clr_en) src_mem[wr_row_q] <= '0;
`endif
    if (cpu_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be_mask[b]) src_mem[cpu_row][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    src_rd_q <= src_mem[cnt_q[RW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_row_q <= '0;
      cpu_col_q <= '0;
    end else begin
      cpu_row_q <= src_mem[cpu_row];
      cpu_col_q <= cpu_col;
    end
  end

  always_comb begin
    cpu_dout = '0;
    for (int c = 0; c < COLS; c++) begin
      if (cpu_col_q == CW'(c)) cpu_dout = cpu_row_q[c*WORD_W +: WORD_W];
    end
  end

  // Display bank: port A takes the registered source row, port B feeds the renderer
  always_ff @(posedge clk) begin
    if (wr_vld_q) disp_mem[wr_row_q] <= src_rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) disp_data_q <= '0;
    else       disp_data_q <= disp_mem[disp_row];
  end

  assign disp_q   = disp_data_q;
  assign dma_busy = busy;
  assign dma_done = done;

endmodule
